// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared encodings and width helper for the mod-N counter
package cnt_pkg;

  localparam int ENC_BIN = 0;
  localparam int ENC_OH  = 1;

  // Bits needed to index v states; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_oh2bin.sv
// rtl/cnt_oh2bin.sv - one-hot to binary encoder for the counter's binary view
module cnt_oh2bin #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] i_oh,
  output logic [W-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int k = 0; k < N; k++) begin
      if (i_oh[k]) o_bin = o_bin | W'(k);
    end
  end

endmodule

// File: rtl/cnt_modn.sv
// rtl/cnt_modn.sv - modulo-N up/down counter with load, tc/wrap flags and selectable encoding
module cnt_modn
  import cnt_pkg::*;
#(
  parameter int N   = 5,
  parameter int W   = (clog2(N) < 1) ? 1 : clog2(N),
  parameter int ENC = ENC_BIN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         up,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q_bin,
  output logic [N-1:0] q_oh,
  output logic         tc,
  output logic         wrap,
  output logic         err
);

  localparam int             SW  = (ENC == ENC_OH) ? N : W;
  localparam logic [W:0]     NW  = (W + 1)'(N);
  localparam logic [W-1:0]   NM1 = W'(N - 1);

  logic [SW-1:0] r_state;
  logic          r_err;
  logic          w_ld_ok;
  logic          w_legal;

  assign w_ld_ok = ({1'b0, ld_val} < NW);

  generate
    if (ENC == ENC_OH) begin : g_oh
      logic [N-1:0] w_up;
      logic [N-1:0] w_dn;
      logic [N-1:0] w_ld;

      // Rotations wrap inside N bits, so a non-power-of-two N never leaves the ring.
      always_comb begin
        w_up = '0;
        w_dn = '0;
        w_ld = '0;
        for (int k = 0; k < N; k++) begin
          w_up[(k + 1) % N] = r_state[k];
          w_dn[k]           = r_state[(k + 1) % N];
          w_ld[k]           = (ld_val == W'(k));
        end
      end

      assign w_legal = (r_state != '0) && ((r_state & (r_state - SW'(1))) == '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= SW'(1);
          r_err   <= 1'b0;
        end else if (ld && w_ld_ok) begin
          r_state <= w_ld;
          r_err   <= 1'b0;
        end else if (ld || !w_legal) begin
          r_state <= SW'(1);
          r_err   <= 1'b1;
        end else begin
          if (inc) r_state <= up ? w_up : w_dn;
          r_err <= 1'b0;
        end
      end

      cnt_oh2bin #(.N(N), .W(W)) u_oh2bin (
        .i_oh  (r_state),
        .o_bin (q_bin)
      );

      assign q_oh = r_state;
    end else begin : g_bin
      assign w_legal = ({1'b0, r_state} < NW);

      // Compare-and-reset at the ends rather than relying on W-bit rollover.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= '0;
          r_err   <= 1'b0;
        end else if (ld && w_ld_ok) begin
          r_state <= ld_val;
          r_err   <= 1'b0;
        end else if (ld || !w_legal) begin
          r_state <= '0;
          r_err   <= 1'b1;
        end else begin
          if (inc) begin
            if (up) r_state <= (r_state == NM1) ? '0 : r_state + W'(1);
            else    r_state <= (r_state == '0) ? NM1 : r_state - W'(1);
          end
          r_err <= 1'b0;
        end
      end

      assign q_bin = r_state;

      always_comb begin
        q_oh = '0;
        for (int k = 0; k < N; k++) begin
          q_oh[k] = (r_state == W'(k));
        end
      end
    end
  endgenerate

  assign tc   = (N == 1) ? 1'b1 : (up ? (q_bin == NM1) : (q_bin == '0));
  assign wrap = inc & ~ld & ~rst & tc;
  assign err  = r_err;

endmodule

// File: tb/tb_cnt_modn.sv
// tb/tb_cnt_modn.sv - randomized bench for cnt_modn across sizes and encodings
module tb_cnt_modn;

  logic       clk = 1'b0;
  logic       rst, inc, up, ld;
  logic [2:0] ld_val3;
  logic [0:0] ld_val1;

  logic [2:0] qb  [4];
  logic [0:0] qb1 [2];
  logic [4:0] qo5 [2];
  logic [5:0] qo6 [2];
  logic [0:0] qo1 [2];
  logic [5:0] tcv, wrv, erv;

  int total = 0;
  int bad   = 0;

  int    mc [6];
  int    me [6];
  int    md [6] = '{5, 5, 6, 6, 1, 1};
  string nm [6] = '{"b5", "o5", "b6", "o6", "b1", "o1"};

  always #5 clk = ~clk;

  cnt_modn #(.N(5), .ENC(0)) u_b5 (.clk(clk), .rst(rst), .inc(inc), .up(up), .ld(ld), .ld_val(ld_val3),
    .q_bin(qb[0]), .q_oh(qo5[0]), .tc(tcv[0]), .wrap(wrv[0]), .err(erv[0]));
  cnt_modn #(.N(5), .ENC(1)) u_o5 (.clk(clk), .rst(rst), .inc(inc), .up(up), .ld(ld), .ld_val(ld_val3),
    .q_bin(qb[1]), .q_oh(qo5[1]), .tc(tcv[1]), .wrap(wrv[1]), .err(erv[1]));
  cnt_modn #(.N(6), .ENC(0)) u_b6 (.clk(clk), .rst(rst), .inc(inc), .up(up), .ld(ld), .ld_val(ld_val3),
    .q_bin(qb[2]), .q_oh(qo6[0]), .tc(tcv[2]), .wrap(wrv[2]), .err(erv[2]));
  cnt_modn #(.N(6), .ENC(1)) u_o6 (.clk(clk), .rst(rst), .inc(inc), .up(up), .ld(ld), .ld_val(ld_val3),
    .q_bin(qb[3]), .q_oh(qo6[1]), .tc(tcv[3]), .wrap(wrv[3]), .err(erv[3]));
  cnt_modn #(.N(1), .ENC(0)) u_b1 (.clk(clk), .rst(rst), .inc(inc), .up(up), .ld(ld), .ld_val(ld_val1),
    .q_bin(qb1[0]), .q_oh(qo1[0]), .tc(tcv[4]), .wrap(wrv[4]), .err(erv[4]));
  cnt_modn #(.N(1), .ENC(1)) u_o1 (.clk(clk), .rst(rst), .inc(inc), .up(up), .ld(ld), .ld_val(ld_val1),
    .q_bin(qb1[1]), .q_oh(qo1[1]), .tc(tcv[5]), .wrap(wrv[5]), .err(erv[5]));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int g_qb(input int k);
    if (k < 4) return int'(qb[k]);
    return int'(qb1[k - 4]);
  endfunction

  function automatic int g_qo(input int k);
    if (k < 2) return int'(qo5[k]);
    if (k < 4) return int'(qo6[k - 2]);
    return int'(qo1[k - 4]);
  endfunction

  // Reference: plain modular arithmetic on an integer count.
  function automatic void model_step(input int k, input bit r, input bit i, input bit u,
                                     input bit l, input int lv);
    int n, v;
    n = md[k];
    v = (n == 1) ? (lv % 2) : (lv % 8);
    if (r) begin
      mc[k] = 0; me[k] = 0;
    end else if (l) begin
      if (v < n) begin mc[k] = v; me[k] = 0; end
      else       begin mc[k] = 0; me[k] = 1; end
    end else begin
      if (i) mc[k] = u ? (mc[k] + 1) % n : (mc[k] - 1 + n) % n;
      me[k] = 0;
    end
  endfunction

  task automatic cycle(input bit r, input bit i, input bit u, input bit l, input int lv,
                       input logic [5:0] skip);
    int c, n, etc;
    rst = r; inc = i; up = u; ld = l;
    ld_val3 = 3'(lv);
    ld_val1 = 1'(lv);
    #1;
    for (int k = 0; k < 6; k++) begin
      if (!skip[k]) begin
        c   = mc[k];
        n   = md[k];
        etc = u ? int'(c == n - 1) : int'(c == 0);
        check($sformatf("%s q_bin", nm[k]), g_qb(k), c);
        check($sformatf("%s q_oh", nm[k]), g_qo(k), 1 << c);
        check($sformatf("%s tc", nm[k]), int'(tcv[k]), etc);
        check($sformatf("%s wrap", nm[k]), int'(wrv[k]), int'(i && !l && !r && etc == 1));
        check($sformatf("%s err", nm[k]), int'(erv[k]), me[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 6; k++) model_step(k, r, i, u, l, lv);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; inc = 1'b0; up = 1'b1; ld = 1'b0; ld_val3 = '0; ld_val1 = '0;
    for (int k = 0; k < 6; k++) begin mc[k] = 0; me[k] = 0; end
    @(negedge clk);

    cycle(1, 0, 1, 0, 0, 6'h3F);
    cycle(1, 0, 1, 0, 0, 6'h00);
    for (int c = 0; c < 12; c++) cycle(0, 1, 1, 0, 0, 6'h00);

    cycle(1, 0, 0, 0, 0, 6'h00);
    for (int c = 0; c < 7; c++) cycle(0, 1, 0, 0, 0, 6'h00);

    cycle(1, 0, 1, 0, 0, 6'h00);
    cycle(0, 1, 1, 0, 0, 6'h00);
    cycle(0, 1, 1, 0, 0, 6'h00);
    cycle(0, 1, 1, 1, 3, 6'h00);
    cycle(0, 1, 1, 1, 6, 6'h00);
    cycle(0, 0, 1, 0, 0, 6'h00);
    cycle(0, 1, 1, 1, 4, 6'h00);
    for (int c = 0; c < 5; c++) cycle(0, 0, c % 2, 0, 0, 6'h00);
    cycle(1, 1, 1, 1, 3, 6'h00);
    cycle(0, 0, 1, 0, 0, 6'h00);

    // Illegal-state recovery: corrupt the N=5 state registers for one edge.
    rst = 1'b0; inc = 1'b1; up = 1'b1; ld = 1'b0;
    force u_b5.r_state = 3'd7;
    force u_o5.r_state = 5'b00110;
    @(posedge clk);
    for (int k = 0; k < 6; k++) model_step(k, 0, 1, 1, 0, 0);
    @(negedge clk);
    release u_b5.r_state;
    release u_o5.r_state;
    check("b5 illegal err", int'(erv[0]), 1);
    check("o5 illegal err", int'(erv[1]), 1);
    mc[0] = 0; mc[1] = 0;
    cycle(0, 0, 1, 0, 0, 6'b000011);
    check("b5 illegal q_bin", g_qb(0), 0);
    check("o5 illegal q_oh", g_qo(1), 1);
    cycle(1, 0, 1, 0, 0, 6'b000011);

    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)), 6'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
